spike_event_fifo: RTL and testbench

Buffers motoneuron and afferent spike events for host readout. Sits directly downstream of the time-multiplexed Izhikevich neuron array and upstream of a block-throttled pipe-out endpoint. Each qualified spike is packed as a two-word record (neuron index, sim-tick timestamp) into an on-chip FIFO that the host drains word by word. Overflow is atomic per event and counted.

---
 rtl/spike_event_fifo.sv | 217 +++++++++++++++++++++
 tb/tb_spike_event_fifo.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_fifo.sv
// spike_event_fifo: packs qualified spike events into two-word records
// (header with neuron index, then 15-bit sim-tick stamp) and buffers them
// in an on-chip word FIFO drained by the host one word per pop.
// Overflow is decided once per event: a record is either stored whole or
// dropped and counted.
module spike_event_fifo #(
    parameter int unsigned NN         = 8,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  tick,
    input  logic                  spike_valid,
    input  logic                  spike_in,
    input  logic [NN:0]           neuron_idx,
    input  logic                  rd_en,
    output logic [15:0]           dout,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   word_count,
    output logic                  overflow,
    output logic [15:0]           dropped_cnt
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;
    localparam int unsigned IW    = NN + 1;
    localparam int unsigned TW    = 15;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WR_HDR = 2'd1;
    localparam logic [1:0] ST_WR_TS  = 2'd2;

    // Registered state
    logic [1:0]            state_q,       state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q,      wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CW-1:0]         word_count_q,  word_count_d;
    logic [TW-1:0]         ts_q,          ts_d;
    logic [IW-1:0]         idx_q,         idx_d;
    logic [TW-1:0]         stamp_q,       stamp_d;
    logic [15:0]           dout_q,        dout_d;
    logic                  empty_q,       empty_d;
    logic                  full_q,        full_d;
    logic                  overflow_q,    overflow_d;
    logic [15:0]           dropped_cnt_q, dropped_cnt_d;

    // Word storage (no reset: contents are only visible through the pointers)
    logic [15:0]           mem_q [DEPTH];

    // Combinational helpers
    logic                  event_c;
    logic                  accept_c;
    logic                  drop_c;
    logic                  wr_en_c;
    logic [15:0]           wr_data_c;
    logic                  pop_c;
    logic [CW-1:0]         free_c;
    logic [15:0]           hdr_word_c;
    logic [15:0]           ts_word_c;

    // Record word formats: bit 15 set marks a header, clear marks a stamp
    always_comb begin
        hdr_word_c = 16'h8000 | 16'(idx_q);
        ts_word_c  = {1'b0, stamp_q};
    end

    // Record-writer FSM: accept an event only when both words are guaranteed to fit
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        stamp_d   = stamp_q;
        accept_c  = 1'b0;
        drop_c    = 1'b0;
        wr_en_c   = 1'b0;
        wr_data_c = 16'h0000;
        event_c   = spike_valid & spike_in;
        free_c    = CW'(DEPTH) - word_count_q;

        case (state_q)
            ST_IDLE: begin
                if (event_c) begin
                    if (free_c >= CW'(2)) begin
                        accept_c = 1'b1;
                        idx_d    = neuron_idx;
                        stamp_d  = ts_q;
                        state_d  = ST_WR_HDR;
                    end else begin
                        drop_c = 1'b1;
                    end
                end
            end
            ST_WR_HDR: begin
                wr_en_c   = 1'b1;
                wr_data_c = hdr_word_c;
                state_d   = ST_WR_TS;
                drop_c    = event_c;
            end
            ST_WR_TS: begin
                wr_en_c   = 1'b1;
                wr_data_c = ts_word_c;
                state_d   = ST_IDLE;
                drop_c    = event_c;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush discards any latched or half-written record
        if (clear) begin
            state_d  = ST_IDLE;
            idx_d    = '0;
            stamp_d  = '0;
            accept_c = 1'b0;
            drop_c   = 1'b0;
            wr_en_c  = 1'b0;
        end
    end

    // Pointer, occupancy, readout and timestamp next-state
    always_comb begin
        pop_c        = rd_en & (word_count_q != '0) & ~clear;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        dout_d       = dout_q;
        word_count_d = word_count_q;
        ts_d         = ts_q;

        if (wr_en_c) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            dout_d   = mem_q[rd_ptr_q];
        end
        word_count_d = word_count_q + CW'(wr_en_c) - CW'(pop_c);

        if (tick) begin
            ts_d = ts_q + TW'(1);
        end

        if (clear) begin
            wr_ptr_d     = '0;
            rd_ptr_d     = '0;
            dout_d       = 16'h0000;
            word_count_d = '0;
            ts_d         = '0;
        end

        empty_d = (word_count_d == '0);
        full_d  = (word_count_d == CW'(DEPTH));
    end

    // Drop bookkeeping: sticky flag plus saturating event counter
    always_comb begin
        overflow_d    = overflow_q;
        dropped_cnt_d = dropped_cnt_q;
        if (drop_c) begin
            overflow_d = 1'b1;
            if (dropped_cnt_q != 16'hFFFF) begin
                dropped_cnt_d = dropped_cnt_q + 16'd1;
            end
        end
        if (clear) begin
            overflow_d    = 1'b0;
            dropped_cnt_d = 16'h0000;
        end
    end

    // State and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            word_count_q  <= '0;
            ts_q          <= '0;
            idx_q         <= '0;
            stamp_q       <= '0;
            dout_q        <= 16'h0000;
            empty_q       <= 1'b1;
            full_q        <= 1'b0;
            overflow_q    <= 1'b0;
            dropped_cnt_q <= 16'h0000;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            word_count_q  <= word_count_d;
            ts_q          <= ts_d;
            idx_q         <= idx_d;
            stamp_q       <= stamp_d;
            dout_q        <= dout_d;
            empty_q       <= empty_d;
            full_q        <= full_d;
            overflow_q    <= overflow_d;
            dropped_cnt_q <= dropped_cnt_d;
        end
    end

    // Word memory write port
    always_ff @(posedge clk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= wr_data_c;
        end
    end

    assign dout        = dout_q;
    assign empty       = empty_q;
    assign full        = full_q;
    assign word_count  = word_count_q;
    assign overflow    = overflow_q;
    assign dropped_cnt = dropped_cnt_q;

endmodule

// File: tb/tb_spike_event_fifo.sv
// Bench for spike_event_fifo: a queue-based record model checked every
// cycle, plus directed literal expectations for the key scenarios.
module tb_spike_event_fifo;

    localparam int unsigned NN         = 8;
    localparam int unsigned DEPTH_LOG2 = 4;
    localparam int          DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                clear = 1'b0;
    logic                tick = 1'b0;
    logic                spike_valid = 1'b0;
    logic                spike_in = 1'b0;
    logic [NN:0]         neuron_idx = '0;
    logic                rd_en = 1'b0;
    logic [15:0]         dout;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] word_count;
    logic                overflow;
    logic [15:0]         dropped_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    spike_event_fifo #(.NN(NN), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clk(clk), .reset(reset), .clear(clear), .tick(tick),
        .spike_valid(spike_valid), .spike_in(spike_in), .neuron_idx(neuron_idx),
        .rd_en(rd_en), .dout(dout), .empty(empty), .full(full),
        .word_count(word_count), .overflow(overflow), .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Behavioural model: a word queue plus "words still owed" by the record in flight
    logic [15:0] mq[$];
    int          m_owed = 0;
    logic [15:0] m_hdr = 16'h0000;
    logic [15:0] m_stamp = 16'h0000;
    logic [14:0] m_ts = 15'd0;
    logic        m_ovf = 1'b0;
    int          m_drop = 0;
    logic [15:0] m_dout = 16'h0000;

    always @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            mq.delete();
            m_owed = 0; m_ts = 15'd0; m_ovf = 1'b0; m_drop = 0; m_dout = 16'h0000;
        end else begin : mdl
            int pre;
            int was;
            bit ev;
            pre = mq.size();
            was = m_owed;
            ev  = spike_valid && spike_in;
            if (rd_en && pre > 0) m_dout = mq.pop_front();
            if (was == 2) begin mq.push_back(m_hdr); m_owed = 1; end
            else if (was == 1) begin mq.push_back(m_stamp); m_owed = 0; end
            if (ev) begin
                if (was == 0 && (DEPTH - pre) >= 2) begin
                    m_hdr   = 16'h8000 + 16'(neuron_idx);
                    m_stamp = {1'b0, m_ts};
                    m_owed  = 2;
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < 65535) m_drop++;
                end
            end
            if (tick) m_ts = m_ts + 15'd1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("dout", 32'(dout), 32'(m_dout));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("word_count", 32'(word_count), 32'(mq.size()));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("dropped_cnt", 32'(dropped_cnt), 32'(m_drop));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        tick = 1'b0; spike_valid = 1'b0; spike_in = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic event_at(input logic [NN:0] idx);
        spike_valid = 1'b1; spike_in = 1'b1; neuron_idx = idx;
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        cmp_en = 1'b1;

        // Reset values
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_word_count", 32'(word_count), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_dropped", 32'(dropped_cnt), 32'h0);

        // 100 idle ticks advance the stamp to 100
        for (int i = 0; i < 100; i++) begin tick = 1'b1; step(); end
        chk("idle_word_count", 32'(word_count), 32'h0);
        event_at(9'h007);
        step(); step();
        pop(); chk("idle_hdr", 32'(dout), 32'h8007);
        pop(); chk("idle_stamp", 32'(dout), 32'h0064);

        // Single event idx 5 at ts 3
        do_clear();
        for (int i = 0; i < 3; i++) begin tick = 1'b1; step(); end
        event_at(9'h005);
        chk("single_empty_k", 32'(empty), 32'h1);
        step();
        chk("single_empty_k1", 32'(empty), 32'h0);
        chk("single_wc_k1", 32'(word_count), 32'h1);
        step();
        chk("single_wc_k2", 32'(word_count), 32'h2);
        pop(); chk("single_hdr", 32'(dout), 32'h8005);
        pop(); chk("single_stamp", 32'(dout), 32'h0003);
        chk("single_empty_end", 32'(empty), 32'h1);

        // Back-to-back events: second dropped, one at k+3 accepted
        event_at(9'h011);
        event_at(9'h012);
        chk("b2b_dropped", 32'(dropped_cnt), 32'h1);
        chk("b2b_overflow", 32'(overflow), 32'h1);
        step();
        event_at(9'h013);
        step(); step();
        chk("b2b_wc", 32'(word_count), 32'h4);
        chk("b2b_dropped_after", 32'(dropped_cnt), 32'h1);
        pop(); chk("b2b_hdr1", 32'(dout), 32'h8011);
        pop(); pop(); chk("b2b_hdr2", 32'(dout), 32'h8013);
        pop();

        // Fill to full, then atomic overflow near the top
        do_clear();
        for (int i = 0; i < DEPTH / 2; i++) begin event_at(9'(i)); step(); step(); step(); end
        chk("fill_full", 32'(full), 32'h1);
        chk("fill_wc", 32'(word_count), 32'(DEPTH));
        event_at(9'h0AA);
        step(); step(); step();
        chk("fill_drop1", 32'(dropped_cnt), 32'h1);
        chk("fill_wc_hold", 32'(word_count), 32'(DEPTH));
        pop();
        chk("fill_pop1_wc", 32'(word_count), 32'(DEPTH - 1));
        chk("fill_pop1_dout", 32'(dout), 32'h8000);
        event_at(9'h0AB);
        chk("fill_drop2", 32'(dropped_cnt), 32'h2);
        pop();
        event_at(9'h0AC);
        step(); step();
        chk("fill_accept_wc", 32'(word_count), 32'(DEPTH));
        chk("fill_accept_drop", 32'(dropped_cnt), 32'h2);

        // Clear while a record is half written
        do_clear();
        event_at(9'h001);
        event_at(9'h002);
        step();
        event_at(9'h003); step(); step();
        event_at(9'h004); step(); step();
        chk("clr_pre_wc", 32'(word_count), 32'h6);
        event_at(9'h006);
        step();
        do_clear();
        chk("clr_wc", 32'(word_count), 32'h0);
        chk("clr_empty", 32'(empty), 32'h1);
        chk("clr_overflow", 32'(overflow), 32'h0);
        chk("clr_dropped", 32'(dropped_cnt), 32'h0);
        step();
        chk("clr_no_resume", 32'(word_count), 32'h0);
        event_at(9'h1AB);
        step(); step();
        pop(); chk("clr_hdr", 32'(dout), 32'h81AB);
        pop(); chk("clr_stamp", 32'(dout), 32'h0000);

        // Timestamp wrap
        do_clear();
        for (int i = 0; i < 32767; i++) begin tick = 1'b1; step(); end
        event_at(9'h1FF);
        step(); step();
        pop(); chk("wrap_hdr", 32'(dout), 32'h81FF);
        pop(); chk("wrap_stamp_max", 32'(dout), 32'h7FFF);
        tick = 1'b1; step();
        tick = 1'b1;
        event_at(9'h010);
        step(); step();
        pop(); chk("wrap_hdr2", 32'(dout), 32'h8010);
        pop(); chk("wrap_stamp_zero", 32'(dout), 32'h0000);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            tick        = ($urandom_range(0, 3) == 0);
            spike_valid = ($urandom_range(0, 2) == 0);
            spike_in    = ($urandom_range(0, 3) != 0);
            neuron_idx  = 9'($urandom);
            rd_en       = ($urandom_range(0, 2) == 0);
            clear       = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        tick = 1'b0; spike_valid = 1'b0; spike_in = 1'b0; rd_en = 1'b0; clear = 1'b0;
        step(); step(); step();
        cmp_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
